interrogate_monitor: RTL
========================

Name: interrogate_monitor

Overview:
- Receive-side checker for the ISS interrogate timing: consumes the ISS reference square wave (UREF1H) and the interrogate pulse (ISSIHI).
- Measures the delay from each reference edge to the interrogate pulse, and the pulse width.
- Emits a one-cycle SAMPLE strobe to the resolver read-out logic when timing is valid; otherwise raises sticky fault flags.
- Sits between the interrogate generator and the angle-sampling logic, clocked by the fast master clock.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for UREF1H and ISSIHI (minimum 2).
- DLY_MIN, 630, minimum legal ref-edge-to-ISSIHI-rise delay in CLOCKH cycles (311 us at 2.048 MHz, minus tolerance).
- DLY_MAX, 645, maximum legal delay in cycles.
- WID_MIN, 4, minimum legal ISSIHI high width in cycles.
- WID_MAX, 8, maximum legal ISSIHI high width in cycles.
- CW, 12, width of the delay counter and DELAY output.

Ports:
- CLOCKH  input  1  master clock; must be at least 1 MHz; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- UREF1H  input  1  ISS reference square wave; asynchronous to CLOCKH.
- ISSIHI  input  1  ISS interrogate pulse; asynchronous to CLOCKH.
- CLR_ERR  input  1  synchronous clear of all sticky error flags.
- SAMPLE  output  1  one-cycle strobe: valid interrogate completed.
- DELAY  output  CW  last measured ref-edge-to-rise delay in cycles.
- WIDTH  output  8  last measured pulse width in cycles.
- EARLY_ERR  output  1  sticky: rise seen before DLY_MIN.
- LATE_ERR  output  1  sticky: rise seen after DLY_MAX.
- MISS_ERR  output  1  sticky: reference edge arrived with no pulse in the preceding half-cycle.
- WID_ERR  output  1  sticky: width out of range, or pulse truncated by a reference edge.
- EXTRA_ERR  output  1  sticky: second pulse within one reference half-cycle.

Behaviour:
- Reset: all outputs 0; DELAY and WIDTH 0; FSM in IDLE; counters 0; synchroniser flops 0; edge-detect history 0.
- Synchronisation: both inputs pass through SYNC_STAGES flops. Edges are detected by comparing the last synchronised value with a history flop. The reference "edge" is either polarity.
- Delay counter (dcnt):
  - Cleared to 0 on the cycle of each reference edge, then increments by 1 per cycle.
  - Saturates at 2^CW-1; never wraps.
- Width counter (wcnt): 8-bit, saturating at 255.
- FSM states:
  - IDLE: ignore ISSIHI. On a reference edge -> WAIT. This suppresses a false MISS_ERR for the first half-cycle after reset.
  - WAIT: on an ISSIHI rise -> PULSE, with wcnt=1 and DELAY<=dcnt. EARLY_ERR is set if dcnt<DLY_MIN; LATE_ERR is set if dcnt>DLY_MAX. On a reference edge with no rise: set MISS_ERR, stay in WAIT, dcnt cleared.
  - PULSE: wcnt increments each cycle ISSIHI is high.
    - On an ISSIHI fall: WIDTH<=wcnt, then -> HOLD. SAMPLE=1 for exactly one cycle (the cycle after the fall is detected) iff the delay was in range and WID_MIN<=wcnt<=WID_MAX. Otherwise set WID_ERR and keep SAMPLE=0.
    - On a reference edge while still high: set WID_ERR, WIDTH<=wcnt, no SAMPLE, -> WAIT with dcnt cleared.
  - HOLD: an ISSIHI rise sets EXTRA_ERR and stays in HOLD (no remeasure). A reference edge -> WAIT.
- Simultaneous events:
  - Reference edge and ISSIHI rise in the same cycle: the reference edge wins; the rise is treated as delay 0 of the new half-cycle, so it goes to PULSE with EARLY_ERR set.
  - CLR_ERR and an error set in the same cycle: set wins.
- Error flags are sticky until CLR_ERR or reset. CLR_ERR does not affect FSM, DELAY or WIDTH.
- Reset asserted mid-pulse: immediate return to the reset state. After release, behaviour resumes from IDLE.

Optional Feature:
- Macro: INTERROGATE_STATS_EN.
- Defined: adds outputs GOOD_CNT[15:0] and BAD_CNT[15:0].
  - GOOD_CNT increments on each SAMPLE.
  - BAD_CNT increments on each cycle in which any error flag is newly set; multiple simultaneous errors count once.
  - Both saturate at 0xFFFF, reset to 0, and are cleared by CLR_ERR.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Nominal: 800 Hz UREF1H, ISSIHI rising 637 cycles after each edge, 6 cycles wide -> DELAY=637, WIDTH=6, one SAMPLE per half-cycle, all error flags 0.
- Early/late: pulse at delay 600, then a pulse at delay 700 -> EARLY_ERR=1 after the first and LATE_ERR=1 after the second; no SAMPLE for either; DELAY=600 then 700.
- Missing and extra: one half-cycle with no pulse -> MISS_ERR=1 at the next edge. One half-cycle with two 6-cycle pulses at 637 and 800 -> one SAMPLE, EXTRA_ERR=1.
- Width: 2-cycle pulse -> WID_ERR=1, WIDTH=2, no SAMPLE. Pulse still high at the next reference edge -> WID_ERR=1, FSM back in WAIT, the following nominal pulse gives SAMPLE.
- Reset/clear: assert rst_n low mid-pulse -> all outputs 0 at once. The first reference half-cycle after release produces no MISS_ERR. CLR_ERR pulse clears the flags; CLR_ERR coincident with a new EARLY_ERR leaves EARLY_ERR=1.
- With INTERROGATE_STATS_EN defined: 10 nominal half-cycles, then 3 bad ones -> GOOD_CNT=10, BAD_CNT=3.

Source files
------------

// File: rtl/interrogate_monitor.sv
// ISS interrogate timing checker: measures ref-edge-to-pulse delay and pulse width,
// strobes SAMPLE on a valid interrogate, else raises sticky faults. Optional INTERROGATE_STATS_EN.
module interrogate_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int DLY_MIN     = 630,
    parameter int DLY_MAX     = 645,
    parameter int WID_MIN     = 4,
    parameter int WID_MAX     = 8,
    parameter int CW          = 12
) (
    input  logic          CLOCKH,
    input  logic          rst_n,
    input  logic          UREF1H,
    input  logic          ISSIHI,
    input  logic          CLR_ERR,
    output logic          SAMPLE,
    output logic [CW-1:0] DELAY,
    output logic [7:0]    WIDTH,
    output logic          EARLY_ERR,
    output logic          LATE_ERR,
    output logic          MISS_ERR,
    output logic          WID_ERR,
    output logic          EXTRA_ERR
`ifdef INTERROGATE_STATS_EN
   ,output logic [15:0]   GOOD_CNT,
    output logic [15:0]   BAD_CNT
`endif
);

    localparam logic [CW-1:0] DMIN   = CW'(DLY_MIN);
    localparam logic [CW-1:0] DMAX   = CW'(DLY_MAX);
    localparam logic [CW-1:0] DC_SAT = '1;
    localparam logic [7:0]    WMIN   = 8'(WID_MIN);
    localparam logic [7:0]    WMAX   = 8'(WID_MAX);

    typedef enum logic [1:0] {IDLE, WAIT, PULSE, HOLD} state_t;

    state_t                 state, nxt;
    logic [SYNC_STAGES-1:0] ref_sync, iss_sync;
    logic                   ref_hist, iss_hist;
    logic                   ref_q, iss_q;
    logic                   ref_edge, iss_rise, iss_fall;
    logic [CW-1:0]          dcnt, dcnt_eff;
    logic [7:0]             wcnt;
    logic                   dly_ok;

    logic early_set, late_set, miss_set, wid_set, extra_set;
    logic start, wid_load, wcnt_inc, sample_nxt, width_ok;

    assign ref_q    = ref_sync[SYNC_STAGES-1];
    assign iss_q    = iss_sync[SYNC_STAGES-1];
    assign ref_edge = ref_q ^ ref_hist;
    assign iss_rise = iss_q & ~iss_hist;
    assign iss_fall = ~iss_q & iss_hist;
    // The edge cycle itself counts as delay 0 of the new half-cycle.
    assign dcnt_eff = ref_edge ? '0 : dcnt;
    assign width_ok = (wcnt >= WMIN) && (wcnt <= WMAX);

    always_ff @(posedge CLOCKH or negedge rst_n) begin
        if (!rst_n) begin
            ref_sync <= '0;
            iss_sync <= '0;
            ref_hist <= 1'b0;
            iss_hist <= 1'b0;
        end else begin
            ref_sync <= {ref_sync[SYNC_STAGES-2:0], UREF1H};
            iss_sync <= {iss_sync[SYNC_STAGES-2:0], ISSIHI};
            ref_hist <= ref_q;
            iss_hist <= iss_q;
        end
    end

    always_ff @(posedge CLOCKH or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt        = state;
        early_set  = 1'b0;
        late_set   = 1'b0;
        miss_set   = 1'b0;
        wid_set    = 1'b0;
        extra_set  = 1'b0;
        start      = 1'b0;
        wid_load   = 1'b0;
        wcnt_inc   = 1'b0;
        sample_nxt = 1'b0;
        case (state)
            IDLE: if (ref_edge) nxt = WAIT;
            WAIT: begin
                if (ref_edge) miss_set = 1'b1;
                if (iss_rise) begin
                    nxt   = PULSE;
                    start = 1'b1;
                end
            end
            PULSE: begin
                if (ref_edge) begin
                    wid_set  = 1'b1;
                    wid_load = 1'b1;
                    nxt      = WAIT;
                end else if (iss_fall) begin
                    wid_load   = 1'b1;
                    sample_nxt = dly_ok & width_ok;
                    wid_set    = ~width_ok;
                    nxt        = HOLD;
                end else if (iss_q) begin
                    wcnt_inc = 1'b1;
                end
            end
            HOLD: begin
                if (ref_edge) begin
                    nxt = WAIT;
                    if (iss_rise) begin
                        nxt   = PULSE;
                        start = 1'b1;
                    end
                end else if (iss_rise) begin
                    extra_set = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
        if (start) begin
            early_set = dcnt_eff < DMIN;
            late_set  = dcnt_eff > DMAX;
        end
    end

    always_ff @(posedge CLOCKH or negedge rst_n) begin
        if (!rst_n) begin
            dcnt   <= '0;
            wcnt   <= '0;
            dly_ok <= 1'b0;
            DELAY  <= '0;
            WIDTH  <= '0;
            SAMPLE <= 1'b0;
        end else begin
            dcnt   <= (dcnt_eff == DC_SAT) ? DC_SAT : dcnt_eff + 1'b1;
            SAMPLE <= sample_nxt;
            if (start) begin
                wcnt   <= 8'd1;
                DELAY  <= dcnt_eff;
                dly_ok <= ~(early_set | late_set);
            end else if (wcnt_inc && wcnt != 8'hFF) begin
                wcnt <= wcnt + 8'd1;
            end
            if (wid_load) WIDTH <= wcnt;
        end
    end

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge CLOCKH or negedge rst_n) begin
        if (!rst_n) begin
            EARLY_ERR <= 1'b0;
            LATE_ERR  <= 1'b0;
            MISS_ERR  <= 1'b0;
            WID_ERR   <= 1'b0;
            EXTRA_ERR <= 1'b0;
        end else begin
            EARLY_ERR <= early_set | (EARLY_ERR & ~CLR_ERR);
            LATE_ERR  <= late_set  | (LATE_ERR  & ~CLR_ERR);
            MISS_ERR  <= miss_set  | (MISS_ERR  & ~CLR_ERR);
            WID_ERR   <= wid_set   | (WID_ERR   & ~CLR_ERR);
            EXTRA_ERR <= extra_set | (EXTRA_ERR & ~CLR_ERR);
        end
    end

`ifdef INTERROGATE_STATS_EN
    logic new_err;
    assign new_err = |({early_set, late_set, miss_set, wid_set, extra_set} &
                       ~{EARLY_ERR, LATE_ERR, MISS_ERR, WID_ERR, EXTRA_ERR});

    always_ff @(posedge CLOCKH or negedge rst_n) begin
        if (!rst_n) begin
            GOOD_CNT <= '0;
            BAD_CNT  <= '0;
        end else if (CLR_ERR) begin
            GOOD_CNT <= '0;
            BAD_CNT  <= '0;
        end else begin
            if (SAMPLE && GOOD_CNT != 16'hFFFF)  GOOD_CNT <= GOOD_CNT + 16'd1;
            if (new_err && BAD_CNT != 16'hFFFF)  BAD_CNT  <= BAD_CNT + 16'd1;
        end
    end
`endif

endmodule
